// File: rtl/vs_rate_limiter_if.sv
// Frame-rate limiter signal bundle: vsync in, target/bypass controls in,
// frame-enable decision and rate measurements out.
interface vs_rate_limiter_if #(
    parameter int unsigned FPS_W = 8
);
    logic             i_vs;
    logic [FPS_W-1:0] i_target_fps;
    logic             i_bypass;
    logic             o_frame_en;
    logic             o_vs_fall;
    logic             o_tick_1s;
    logic [FPS_W-1:0] o_in_fps;
    logic [FPS_W-1:0] o_out_fps;

    modport master (
        output i_vs, i_target_fps, i_bypass,
        input  o_frame_en, o_vs_fall, o_tick_1s, o_in_fps, o_out_fps
    );

    modport slave (
        input  i_vs, i_target_fps, i_bypass,
        output o_frame_en, o_vs_fall, o_tick_1s, o_in_fps, o_out_fps
    );
endinterface

// File: rtl/vs_rate_limiter.sv
// Frame-rate scheduler: measures vsync rate over a CLK_FREQ-cycle window and
// decides per frame whether to forward it, spreading passed frames evenly
// with an error accumulator.
module vs_rate_limiter #(
    parameter int unsigned CLK_FREQ = 65_000_000,
    parameter int unsigned FPS_W    = 8
) (
    input logic              post_clk,
    input logic              sys_rst,
    vs_rate_limiter_if.slave bus
);
    localparam int unsigned WIN_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        ST_CALIB  = 2'd0,
        ST_RUN    = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_vs_d;
    logic [WIN_W-1:0] r_win_cnt;
    logic [FPS_W-1:0] r_in_cnt;
    logic [FPS_W-1:0] r_out_cnt;
    logic [FPS_W:0]   r_acc;
    logic             r_frame_en;
    logic             r_vs_fall;
    logic             r_tick;
    logic [FPS_W-1:0] r_in_fps;
    logic [FPS_W-1:0] r_out_fps;

    logic             w_fall;
    logic             w_win_end;
    logic             w_pass;
    logic [FPS_W:0]   w_acc_nxt;
    logic [FPS_W:0]   w_sum;
    logic [FPS_W:0]   w_r_ext;
    logic [FPS_W-1:0] w_in_next;
    logic [FPS_W-1:0] w_out_next;

    assign w_fall    = r_vs_d & ~bus.i_vs;
    assign w_win_end = (r_win_cnt == WIN_MAX);
    assign w_r_ext   = {1'b0, r_in_fps};
    assign w_sum     = r_acc + {1'b0, bus.i_target_fps};

    // Counter values including this cycle's boundary, saturating at all-ones;
    // used both for the running count and for the window-end latch.
    assign w_in_next  = (w_fall && (r_in_cnt != '1)) ? r_in_cnt + 1'b1 : r_in_cnt;
    assign w_out_next = (w_fall && w_pass && (r_out_cnt != '1)) ? r_out_cnt + 1'b1 : r_out_cnt;

    // Per-frame pass/block decision and accumulator update
    always_comb begin
        w_pass    = 1'b1;
        w_acc_nxt = r_acc;
        if (r_state == ST_RUN) begin
            if (bus.i_target_fps >= r_in_fps) begin
                w_pass    = 1'b1;
                w_acc_nxt = '0;
            end else if (bus.i_target_fps == '0) begin
                w_pass    = 1'b0;
            end else if (w_sum >= w_r_ext) begin
                w_pass    = 1'b1;
                w_acc_nxt = w_sum - w_r_ext;
            end else begin
                w_pass    = 1'b0;
                w_acc_nxt = w_sum;
            end
        end
    end

    // Next-state logic; bypass request overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_bypass) begin
            w_state_nxt = ST_BYPASS;
        end else begin
            unique case (r_state)
                ST_BYPASS: w_state_nxt = ST_CALIB;
                ST_CALIB:  if (w_win_end && (w_in_next != '0)) w_state_nxt = ST_RUN;
                ST_RUN:    if (w_win_end && (w_in_next == '0)) w_state_nxt = ST_CALIB;
                default:   w_state_nxt = ST_CALIB;
            endcase
        end
    end

    // State register
    always_ff @(posedge post_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= ST_CALIB;
        else         r_state <= w_state_nxt;
    end

    // Accumulator: cleared on entry to RUN, otherwise updated at RUN boundaries
    always_ff @(posedge post_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc <= '0;
        end else if ((w_state_nxt == ST_RUN) && (r_state != ST_RUN)) begin
            r_acc <= '0;
        end else if (w_fall && (r_state == ST_RUN)) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Edge detect, window timer, frame counters and registered outputs
    always_ff @(posedge post_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_vs_d     <= 1'b0;
            r_win_cnt  <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_frame_en <= 1'b1;
            r_vs_fall  <= 1'b0;
            r_tick     <= 1'b0;
            r_in_fps   <= '0;
            r_out_fps  <= '0;
        end else begin
            r_vs_d    <= bus.i_vs;
            r_vs_fall <= w_fall;
            r_tick    <= w_win_end;
            if (w_fall) r_frame_en <= w_pass;
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_in_fps  <= w_in_next;
                r_out_fps <= w_out_next;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_in_cnt  <= w_in_next;
                r_out_cnt <= w_out_next;
            end
        end
    end

    assign bus.o_frame_en = r_frame_en;
    assign bus.o_vs_fall  = r_vs_fall;
    assign bus.o_tick_1s  = r_tick;
    assign bus.o_in_fps   = r_in_fps;
    assign bus.o_out_fps  = r_out_fps;
endmodule

// File: tb/tb_vs_rate_limiter.sv
// Scoreboard bench for vs_rate_limiter with a 1000-cycle window.
module tb_vs_rate_limiter;
    localparam int unsigned CF    = 1000;
    localparam int unsigned FW    = 8;
    localparam int unsigned FMAX  = 255;
    localparam int M_CALIB = 0;
    localparam int M_RUN   = 1;
    localparam int M_BYP   = 2;

    logic post_clk;
    logic sys_rst;

    vs_rate_limiter_if #(.FPS_W(FW)) vif ();

    vs_rate_limiter #(.CLK_FREQ(CF), .FPS_W(FW)) dut (
        .post_clk (post_clk),
        .sys_rst  (sys_rst),
        .bus      (vif)
    );

    initial begin
        post_clk = 1'b0;
        forever #5 post_clk = ~post_clk;
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard queues, filled by the driver's frame-level model
    bit          q_fen[$];
    int unsigned q_in[$];
    int unsigned q_out[$];

    // Frame-level reference state (driver process only)
    int          md;
    int unsigned acc, rr, tt, in_cnt, out_cnt, cyc, ph, per, frames_driven;
    bit          prev_vs;

    // Monitor state
    int unsigned mon_cyc;
    int unsigned tot_in;
    bit          seen_tick;
    bit          e_fen;
    int unsigned e_in, e_out;

    always @(posedge post_clk or posedge sys_rst) begin
        if (sys_rst) mon_cyc <= 0;
        else         mon_cyc <= mon_cyc + 1;
    end

    always @(negedge post_clk) begin
        if (sys_rst) begin
            seen_tick <= 1'b0;
        end else begin
            if (vif.o_vs_fall) begin
                if (q_fen.size() == 0) check_eq("fen_underflow", 0, 1);
                else begin
                    e_fen = q_fen.pop_front();
                    check_eq("frame_en", vif.o_frame_en, e_fen);
                end
            end
            if (vif.o_tick_1s) begin
                if (!seen_tick) check_eq("first_tick_cycle", mon_cyc, CF);
                seen_tick <= 1'b1;
                tot_in    <= tot_in + vif.o_in_fps;
                if (q_in.size() == 0) check_eq("tick_underflow", 0, 1);
                else begin
                    e_in  = q_in.pop_front();
                    e_out = q_out.pop_front();
                    check_eq("in_fps", vif.o_in_fps, e_in);
                    check_eq("out_fps", vif.o_out_fps, e_out);
                end
            end
        end
    end

    // One cycle of stimulus plus the reference model's reaction to it
    task automatic step(input bit vs);
        bit bnd, pass, wend;
        int nm;
        int unsigned s;
        vif.i_vs = vs;
        bnd  = prev_vs && !vs;
        wend = (cyc % CF) == CF - 1;
        if (bnd) begin
            frames_driven++;
            pass = 1'b1;
            if (md == M_RUN) begin
                tt = vif.i_target_fps;
                if (tt >= rr) begin
                    pass = 1'b1; acc = 0;
                end else if (tt == 0) begin
                    pass = 1'b0;
                end else begin
                    s = acc + tt;
                    if (s >= rr) begin pass = 1'b1; acc = s - rr; end
                    else         begin pass = 1'b0; acc = s; end
                end
            end
            q_fen.push_back(pass);
            if (in_cnt < FMAX) in_cnt++;
            if (pass && out_cnt < FMAX) out_cnt++;
        end
        if (wend) begin
            q_in.push_back(in_cnt);
            q_out.push_back(out_cnt);
            rr = in_cnt;
            in_cnt = 0;
            out_cnt = 0;
        end
        nm = md;
        if (vif.i_bypass) nm = M_BYP;
        else if (md == M_BYP) nm = M_CALIB;
        else if (wend && md == M_CALIB && rr != 0) nm = M_RUN;
        else if (wend && md == M_RUN && rr == 0) nm = M_CALIB;
        if (nm == M_RUN && md != M_RUN) acc = 0;
        md = nm;
        prev_vs = vs;
        @(posedge post_clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(ph < per / 2);
            ph = (ph + 1) % per;
        end
    endtask

    task automatic hold_low(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0);
    endtask

    // Called just after a rising edge; the cycle that follows is window cycle 0
    task automatic release_reset();
        sys_rst = 1'b0;
        cyc = 0; prev_vs = 1'b0; md = M_CALIB;
        acc = 0; rr = 0; in_cnt = 0; out_cnt = 0; ph = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_frame_en"}, vif.o_frame_en, 1);
        check_eq({tag, "_vs_fall"},  vif.o_vs_fall, 0);
        check_eq({tag, "_tick"},     vif.o_tick_1s, 0);
        check_eq({tag, "_in_fps"},   vif.o_in_fps, 0);
        check_eq({tag, "_out_fps"},  vif.o_out_fps, 0);
    endtask

    int unsigned tot0, fr0;

    initial begin
        sys_rst = 1'b1;
        vif.i_vs = 1'b0;
        vif.i_bypass = 1'b0;
        vif.i_target_fps = 8'd10;
        tot_in = 0;
        frames_driven = 0;
        per = 50;
        repeat (3) @(posedge post_clk);
        #1;
        check_reset_vals("por");
        release_reset();
        run(300);

        // Asynchronous reset mid-window while vsync keeps toggling
        @(posedge post_clk);
        #3;
        sys_rst = 1'b1;
        q_fen.delete(); q_in.delete(); q_out.delete();
        vif.i_vs = ~vif.i_vs;
        #1;
        check_reset_vals("rst_mid");
        repeat (4) begin
            @(posedge post_clk);
            #1;
            vif.i_vs = ~vif.i_vs;
        end
        vif.i_vs = 1'b1;
        @(posedge post_clk);
        #1;
        check_reset_vals("rst_hold");
        release_reset();
        step(1'b0);               // falling edge right after release: ignored

        // Calibration window, then RUN at target 10 of 20
        run(CF * 2 - 1);
        check_eq("cal_in_fps", vif.o_in_fps, 20);
        check_eq("run10_out_fps", vif.o_out_fps, 10);

        vif.i_target_fps = 8'd5;
        run(CF);
        check_eq("run5_out_fps", vif.o_out_fps, 5);

        vif.i_target_fps = 8'd30;
        run(CF);
        check_eq("run30_out_fps", vif.o_out_fps, 20);

        vif.i_target_fps = 8'd0;
        run(CF);
        check_eq("run0_out_fps", vif.o_out_fps, 0);
        check_eq("run0_frame_en", vif.o_frame_en, 0);

        // Shift phase so a boundary lands on every window end
        vif.i_target_fps = 8'd10;
        fr0 = frames_driven;
        hold_low(1);
        tot0 = tot_in;
        hold_low(23);
        ph = 0;
        run(CF * 3 - 24);
        check_eq("coinc_in_fps", vif.o_in_fps, 20);
        hold_low(1);
        check_eq("coinc_total", tot_in - tot0, frames_driven - fr0);

        // Source loss for one full window, then restart in CALIB
        hold_low(CF - 1);
        check_eq("loss_in_fps", vif.o_in_fps, 0);
        ph = 0;
        run(CF);
        check_eq("recal_out_fps", vif.o_out_fps, 20);

        // Bypass pulse while in RUN
        vif.i_target_fps = 8'd5;
        run(CF / 2);
        vif.i_bypass = 1'b1;
        run(300);
        vif.i_bypass = 1'b0;
        run(200);
        run(CF);
        check_eq("post_byp_out_fps", vif.o_out_fps, 5);

        // Saturation: vsync period 2 gives 500 frames per window
        per = 2;
        ph = 0;
        run(CF);
        check_eq("sat_in_fps", vif.o_in_fps, FMAX);

        hold_low(3);
        check_eq("fen_left", q_fen.size(), 0);
        check_eq("tick_left", q_in.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vs_rate_limiter.md
Name: vs_rate_limiter

Overview:
Frame-rate scheduler for the video pipeline. It measures the incoming vsync rate over a 1 s window and decides, frame by frame, whether each frame is forwarded downstream, so the output rate tracks a programmable target fps. Decisions use error accumulation, so passed frames are spread evenly across the second rather than bunched. It sits on the post-processing clock, between the vsync source and the frame-buffer write enable.

Parameters:
CLK_FREQ, 65_000_000, post_clk cycles per measurement window (window = CLK_FREQ cycles exactly)
FPS_W, 8, width of all fps counters and fps outputs

Ports:
post_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  asynchronous, active-high reset
i_vs  input  1  vsync, synchronous to post_clk; frame boundary = falling edge
i_target_fps  input  FPS_W  requested output frame rate
i_bypass  input  1  1 = forward every frame, limiter disabled
o_frame_en  output  1  1 = current frame is forwarded; held constant between boundaries
o_vs_fall  output  1  one-cycle pulse per detected frame boundary
o_tick_1s  output  1  one-cycle pulse at the end of each window
o_in_fps  output  FPS_W  measured input frames in the last completed window
o_out_fps  output  FPS_W  frames forwarded in the last completed window

Behaviour:
- Interface: one clock, post_clk. sys_rst is asynchronous and active-high.
- Reset values:
  - o_frame_en=1.
  - All other outputs 0.
  - Window counter, frame counters and accumulator 0.
  - vs history register 0.
  - FSM in CALIB.
- Edge detect:
  - vs_d holds last cycle's i_vs.
  - Boundary when vs_d=1 and i_vs=0 in cycle N.
  - o_vs_fall and the o_frame_en update are both registered and visible in cycle N+1.
- Window timer: counts 0..CLK_FREQ-1 and wraps to 0. o_tick_1s is asserted in the cycle after count reaches CLK_FREQ-1.
- Counters in_cnt and out_cnt:
  - Increment on each boundary; out_cnt only when that boundary's decision is pass.
  - Both saturate at 2^FPS_W-1.
  - At window end, o_in_fps and o_out_fps latch the counts, including a boundary occurring in that same cycle. The counters then restart at 0, with no event lost or double-counted.
- FSM states:
  - CALIB: pass every frame; no valid rate yet.
  - RUN: accumulator decisions.
  - BYPASS: pass every frame.
- FSM transitions:
  - Any state -> BYPASS whenever i_bypass=1, checked every cycle, with priority over all other transitions.
  - BYPASS -> CALIB on the cycle after i_bypass returns to 0.
  - CALIB -> RUN at window end if the newly latched in_fps != 0. The accumulator clears on entry.
  - RUN -> CALIB at window end if the newly latched in_fps == 0 (source lost).
- RUN decision at each boundary, using R = o_in_fps and T = i_target_fps sampled at that boundary:
  - If T >= R: pass, and acc clears to 0.
  - Else if T == 0: block, and acc is unchanged.
  - Else: acc_next = acc + T. If acc_next >= R: pass and acc = acc_next - R. Otherwise block and acc = acc_next.
  - acc is FPS_W+1 bits wide and never overflows, since acc < R before each add.
- A new R latched at window end applies from the next boundary; acc is kept unless the FSM changes state.
- Target changes take effect at the next boundary only; o_frame_en never changes between boundaries.
- CALIB and BYPASS: o_frame_en <= 1 at each boundary; out_cnt counts every frame.
- Reset asserted mid-frame: immediate return to reset values. A falling edge in the first cycle after release is ignored, because vs_d = 0.

Test Plan:
- Reset: assert sys_rst mid-window with i_vs toggling -> all outputs 0 except o_frame_en=1. After release, the first o_tick_1s is exactly CLK_FREQ cycles later.
- Measurement and calibration: CLK_FREQ=1000, vs period 50 cycles, target 10.
  - First tick -> o_in_fps=20, FSM enters RUN.
  - Following boundaries give o_frame_en 0,1,0,1...
  - Next tick -> o_out_fps=10.
- Decimation and pass-through:
  - Target 5 at 20 fps input -> exactly every 4th frame passes, o_out_fps=5.
  - Target 30 -> every frame passes, o_out_fps=20.
  - Target 0 -> o_frame_en=0 for all frames, o_out_fps=0.
- Coincident events: boundary in the same cycle as window end -> that frame is counted in the closing o_in_fps, the new window starts at 0, and the total over 3 windows equals the frames driven.
- Source loss and bypass:
  - Stop i_vs for a full window -> o_in_fps=0 and FSM returns to CALIB. After restarting i_vs, o_frame_en=1 until the next tick.
  - Pulse i_bypass high in RUN -> all frames pass. After it drops, the FSM is in CALIB and returns to RUN after one tick.
- Saturation: CLK_FREQ=1000, vs period 2 cycles -> o_in_fps=255 (saturated, no wrap).
